// File: rtl/coax_tx.sv
// 3270 coax transmit serializer: frames 10-bit words with start/sync/parity/end
// sequences and drives biphase-encoded line outputs with a delayed pre-emphasis copy.
module coax_tx #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DELAY_CLOCKS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx_active,
    output logic       tx,
    output logic       tx_delay,
    output logic       tx_inverted
);

    localparam int PW = $clog2(CLOCKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST = PW'(CLOCKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLOCKS_PER_BIT / 2);
    localparam logic [PW-1:0] PH_HEND = PW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [PW-1:0] DR_LAST = PW'(DELAY_CLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WORD,
        S_END,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_ph;
    logic [3:0]              r_cell;
    logic [11:0]             r_shift;
    logic [9:0]              r_hold;
    logic                    r_empty;
    logic                    r_tx;
    logic                    r_active;
    logic                    r_inv;
    logic [DELAY_CLOCKS-1:0] r_dly;

    state_t        w_state;
    logic [PW-1:0] w_ph;
    logic [3:0]    w_cell;
    logic [11:0]   w_shift;
    logic          w_load;
    logic          w_bypass;
    logic          w_accept;
    logic          w_ph_last;
    logic          w_tx;

    function automatic logic [11:0] frame(input logic [9:0] d);
        return {1'b1, d, ^d};
    endfunction

    assign w_accept  = data_valid & r_empty;
    assign w_ph_last = (r_ph == PH_LAST);

    always_comb begin
        w_state  = r_state;
        w_ph     = r_ph;
        w_cell   = r_cell;
        w_shift  = r_shift;
        w_load   = 1'b0;
        w_bypass = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_state = S_START;
                    w_ph    = '0;
                    w_cell  = '0;
                    w_shift = frame(r_hold);
                    w_load  = 1'b1;
                end
            end
            S_START: begin
                w_ph = r_ph + 1'b1;
                if (w_ph_last) begin
                    w_ph   = '0;
                    w_cell = r_cell + 4'd1;
                    if (r_cell == 4'd7) begin
                        w_state = S_WORD;
                        w_cell  = '0;
                    end
                end
            end
            S_WORD: begin
                w_ph = r_ph + 1'b1;
                if (w_ph_last) begin
                    w_ph    = '0;
                    w_cell  = r_cell + 4'd1;
                    w_shift = {r_shift[10:0], 1'b0};
                    if (r_cell == 4'd11) begin
                        w_cell = '0;
                        // chain without a gap; a word arriving right now bypasses holding
                        if (!r_empty) begin
                            w_shift = frame(r_hold);
                            w_load  = 1'b1;
                        end else if (data_valid) begin
                            w_shift  = frame(data);
                            w_bypass = 1'b1;
                        end else begin
                            w_state = S_END;
                        end
                    end
                end
            end
            S_END: begin
                w_ph = r_ph + 1'b1;
                if (w_ph_last) begin
                    w_ph   = '0;
                    w_cell = r_cell + 4'd1;
                end
                if (r_cell == 4'd2 && r_ph == PH_HEND) begin
                    w_state = S_DRAIN;
                    w_ph    = '0;
                    w_cell  = '0;
                end
            end
            S_DRAIN: begin
                w_ph = r_ph + 1'b1;
                if (r_ph == DR_LAST) begin
                    w_state = S_IDLE;
                    w_ph    = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // line level for the cycle the next state describes, so the pins are registered
    always_comb begin
        w_tx = 1'b0;
        unique case (w_state)
            S_START: begin
                if (w_cell < 4'd5)
                    w_tx = (w_ph >= PH_HALF);
                else
                    w_tx = (w_cell == 4'd5) ||
                           (w_cell == 4'd6 && w_ph < PH_HALF);
            end
            S_WORD:
                w_tx = w_shift[11] ? (w_ph >= PH_HALF) : (w_ph < PH_HALF);
            S_END:
                w_tx = (w_cell == 4'd0) ? (w_ph < PH_HALF) : 1'b1;
            default: w_tx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_cell   <= '0;
            r_shift  <= '0;
            r_hold   <= '0;
            r_empty  <= 1'b1;
            r_tx     <= 1'b0;
            r_active <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ph     <= w_ph;
            r_cell   <= w_cell;
            r_shift  <= w_shift;
            if (w_load)
                r_empty <= 1'b1;
            if (w_accept && !w_bypass) begin
                r_hold  <= data;
                r_empty <= 1'b0;
            end
            r_tx     <= w_tx;
            r_active <= (w_state != S_IDLE);
            r_inv    <= (w_state != S_IDLE) & ~w_tx;
        end
    end

    generate
        if (DELAY_CLOCKS == 1) begin : g_dly1
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_dly <= '0;
                else
                    r_dly <= r_tx;
            end
        end else begin : g_dlyn
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_dly <= '0;
                else
                    r_dly <= {r_dly[DELAY_CLOCKS-2:0], r_tx};
            end
        end
    endgenerate

    assign ready       = r_empty;
    assign tx_active   = r_active;
    assign tx          = r_tx;
    assign tx_delay    = r_dly[DELAY_CLOCKS-1];
    assign tx_inverted = r_inv;

endmodule
